data_memory_lsu: RTL and testbench

//  Byte-addressed data memory with load/store unit for the pipeline MEM stage.

---
 rtl/data_memory_lsu.sv | 176 +++++++++++++++++
 tb/tb_data_memory_lsu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
// Data memory with load/store unit for the MEM stage.
// Lane-masked stores, extended loads, req/ready/valid with fixed read latency.
module data_memory_lsu #(
    parameter int MEM_DEPTH   = 1024,
    parameter int DATA_LENGTH = 32,
    parameter int ADDR_LENGTH = 32,
    parameter int RD_LATENCY  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req,
    output logic                   o_ready,
    input  logic                   i_we,
    input  logic [ADDR_LENGTH-1:0] i_Addr,
    input  logic [1:0]             i_size,
    input  logic                   i_unsigned,
    input  logic [DATA_LENGTH-1:0] i_Data,
    output logic                   o_valid,
    output logic [DATA_LENGTH-1:0] o_Data,
    output logic                   o_err
);

    localparam int B  = DATA_LENGTH / 8;
    localparam int LB = $clog2(B);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                   state_q;
    logic [1:0]               cnt_q;
    logic                     we_q;
    logic                     err_q;
    logic                     uns_q;
    logic [1:0]               size_q;
    logic [LB-1:0]            lane_q;
    logic [DATA_LENGTH-1:0]   rdata_q;
    logic [DATA_LENGTH-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_LENGTH-1:0]   idx;
    logic [LB-1:0]            lane;
    logic [IW-1:0]            widx;
    logic                     accept;
    logic                     mis;
    logic                     err_d;
    logic [B-1:0]             be_d;
    logic [DATA_LENGTH-1:0]   wdata_d;
    logic [DATA_LENGTH-1:0]   sh;
    logic [DATA_LENGTH-1:0]   mask;
    logic                     sgn;
    logic [DATA_LENGTH-1:0]   ld_d;

    assign idx     = i_Addr >> LB;
    assign lane    = i_Addr[LB-1:0];
    assign widx    = idx[IW-1:0];
    assign o_ready = (state_q == IDLE) & ~i_rst;
    assign accept  = i_req & o_ready;
    assign wdata_d = i_Data << {lane, 3'b000};

    // Request decode: alignment/range check and store byte enables
    always_comb begin
        mis  = 1'b0;
        be_d = '0;
        unique case (i_size)
            2'b00: begin
                mis  = 1'b0;
                be_d = B'(1) << lane;
            end
            2'b01: begin
                mis  = lane[0];
                be_d = B'(3) << lane;
            end
            2'b10: begin
                mis  = |lane[1:0];
                be_d = B'(15) << lane;
            end
            default: begin
                mis  = (DATA_LENGTH == 32) ? 1'b1 : |lane;
                be_d = '1;
            end
        endcase
        err_d = mis | (idx >= ADDR_LENGTH'(MEM_DEPTH));
    end

    // Load extraction: shift selected field to bit 0, then extend
    always_comb begin
        sh   = rdata_q >> {lane_q, 3'b000};
        mask = '1;
        sgn  = sh[DATA_LENGTH-1];
        unique case (size_q)
            2'b00: begin
                mask = DATA_LENGTH'(8'hFF);
                sgn  = sh[7];
            end
            2'b01: begin
                mask = DATA_LENGTH'(16'hFFFF);
                sgn  = sh[15];
            end
            2'b10: begin
                mask = DATA_LENGTH'(32'hFFFF_FFFF);
                sgn  = sh[31];
            end
            default: begin
                mask = '1;
                sgn  = sh[DATA_LENGTH-1];
            end
        endcase
        ld_d = (sh & mask) | ((~uns_q & sgn) ? ~mask : '0);
    end

    // RAM: lane-masked store and word read, both on the accept edge
    always_ff @(posedge i_clk) begin
        if (accept && !err_d) begin
            if (i_we) begin
                for (int b = 0; b < B; b++) begin
                    if (be_d[b]) begin
                        mem_q[widx][8*b +: 8] <= wdata_d[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[widx];
            end
        end
    end

    // Control FSM with registered response outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            lane_q  <= '0;
            o_valid <= 1'b0;
            o_Data  <= '0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        cnt_q   <= i_we ? 2'd0 : 2'(RD_LATENCY - 1);
                        we_q    <= i_we;
                        err_q   <= err_d;
                        uns_q   <= i_unsigned;
                        size_q  <= i_size;
                        lane_q  <= lane;
                    end
                end
                BUSY: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= RESP;
                        o_valid <= 1'b1;
                        o_err   <= err_q;
                        o_Data  <= (we_q | err_q) ? '0 : ld_d;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: directed cases plus random traffic
// compared every cycle against a byte-level memory model.
module tb_data_memory_lsu;

    localparam int LAT = 3;
    localparam int DEP = 1024;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        o_ready;
    logic        i_we;
    logic [31:0] i_Addr;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_Data;
    logic        o_valid;
    logic [31:0] o_Data;
    logic        o_err;

    data_memory_lsu #(
        .MEM_DEPTH(DEP),
        .DATA_LENGTH(32),
        .ADDR_LENGTH(32),
        .RD_LATENCY(LAT)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_req(i_req),
        .o_ready(o_ready),
        .i_we(i_we),
        .i_Addr(i_Addr),
        .i_size(i_size),
        .i_unsigned(i_unsigned),
        .i_Data(i_Data),
        .o_valid(o_valid),
        .o_Data(o_Data),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [DEP];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          busy_until = -1;
    logic [31:0] last_d = 0;
    logic        last_e = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
        int nb;
        nb = 1 << sz;
        return (sz == 2'd3) || ((a >> 2) >= DEP) || ((a % nb) != 0);
    endfunction

    function automatic void m_store(input logic [31:0] a,
                                    input logic [1:0] sz,
                                    input logic [31:0] d);
        int idx;
        int ln;
        int nb;
        logic [31:0] w;
        idx = int'(a >> 2);
        ln  = int'(a & 32'd3);
        nb  = 1 << sz;
        w   = mem_m[idx];
        for (int b = 0; b < nb; b++) w[8*(ln+b) +: 8] = d[8*b +: 8];
        mem_m[idx] = w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input bit u);
        int idx;
        int ln;
        int bits;
        longint f;
        idx  = int'(a >> 2);
        ln   = int'(a & 32'd3);
        bits = 8 * (1 << sz);
        f    = longint'(mem_m[idx]) >> (8 * ln);
        f    = f & ((64'sd1 << bits) - 1);
        if (!u && f[bits-1]) f = f - (64'sd1 << bits);
        return f[31:0];
    endfunction

    // One request: wait for ready, record expectations at the accept edge
    task automatic op(input bit we, input logic [31:0] a, input logic [1:0] sz,
                      input bit u, input logic [31:0] d, input bit keep);
        int   n;
        int   acc;
        int   lat;
        bit   er;
        exp_t e;
        @(negedge i_clk);
        i_req      = 1'b1;
        i_we       = we;
        i_Addr     = a;
        i_size     = sz;
        i_unsigned = u;
        i_Data     = d;
        n = 0;
        while (!o_ready) begin
            @(negedge i_clk);
            n++;
            if (n > 50) begin
                checks++;
                fails++;
                $display("FAIL accept_timeout: got no ready, required ready");
                i_req = 1'b0;
                return;
            end
        end
        acc = cyc + 1;
        lat = we ? 1 : LAT;
        er  = m_err(a, sz);
        if (!er && we) m_store(a, sz, d);
        e.cyc = acc + lat;
        e.d   = (er || we) ? 32'd0 : m_load(a, sz, u);
        e.e   = er;
        q.push_back(e);
        busy_until = acc + lat;
        @(posedge i_clk);
        #1;
        if (!keep) i_req = 1'b0;
        i_we       = 1'($urandom);
        i_Addr     = $urandom;
        i_size     = 2'($urandom);
        i_unsigned = 1'($urandom);
        i_Data     = $urandom;
    endtask

    task automatic wait_resp(input string nm, input logic [31:0] d,
                             input logic e, input int lat);
        int k;
        k = 0;
        do begin
            @(posedge i_clk);
            #2;
            k++;
        end while (!o_valid && k < 20);
        chk({nm, "_lat"}, k, lat);
        chk({nm, "_data"}, o_Data, d);
        chk({nm, "_err"}, o_err, e);
    endtask

    // Every-cycle comparison against the model
    initial begin
        bit er;
        forever begin
            @(posedge i_clk);
            cyc++;
            #1;
            er = !i_rst && (cyc > busy_until);
            chk("ready", o_ready, er);
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("valid", o_valid, 1);
                chk("resp_data", o_Data, q[0].d);
                chk("resp_err", o_err, q[0].e);
                last_d = q[0].d;
                last_e = q[0].e;
                void'(q.pop_front());
            end else begin
                chk("valid", o_valid, 0);
                chk("hold_data", o_Data, last_d);
                chk("hold_err", o_err, last_e);
            end
        end
    end

    initial begin
        int k;
        int gap;
        bit keep;
        logic [31:0] a;
        int r;
        i_rst = 1'b1;
        i_req = 1'b0;
        i_we = 1'b0;
        i_Addr = '0;
        i_size = '0;
        i_unsigned = 1'b0;
        i_Data = '0;
        repeat (3) @(posedge i_clk);
        #2;
        chk("rst_ready", o_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_Data, 0);
        chk("rst_err", o_err, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #2;
        chk("post_rst_ready", o_ready, 1);

        op(1, 32'h10, 2, 0, 32'h8000_00F0, 0);
        wait_resp("sw1", 0, 0, 1);
        op(0, 32'h10, 2, 0, 0, 0);
        wait_resp("lw1", 32'h8000_00F0, 0, LAT);

        op(1, 32'h10, 2, 0, 32'h1122_3344, 0);
        wait_resp("sw2", 0, 0, 1);
        op(1, 32'h12, 0, 0, 32'h5A5A_5AAB, 0);
        wait_resp("sb2", 0, 0, 1);
        op(0, 32'h10, 2, 0, 0, 0);
        wait_resp("lw2", 32'h11AB_3344, 0, LAT);
        op(0, 32'h12, 0, 0, 0, 0);
        wait_resp("lb2", 32'hFFFF_FFAB, 0, LAT);
        op(0, 32'h12, 0, 1, 0, 0);
        wait_resp("lbu2", 32'h0000_00AB, 0, LAT);

        op(1, 32'h0, 2, 0, 32'h0000_8001, 0);
        wait_resp("sw3", 0, 0, 1);
        op(0, 32'h0, 1, 0, 0, 0);
        wait_resp("lh3", 32'hFFFF_8001, 0, LAT);
        op(0, 32'h0, 1, 1, 0, 0);
        wait_resp("lhu3", 32'h0000_8001, 0, LAT);
        op(0, 32'h2, 1, 0, 0, 0);
        wait_resp("lh3_hi", 32'h0, 0, LAT);

        op(0, 32'h2, 2, 0, 0, 0);
        wait_resp("lw_mis", 0, 1, LAT);
        op(1, 32'h1, 1, 0, 32'hFFFF_FFFF, 0);
        wait_resp("sh_mis", 0, 1, 1);
        op(0, DEP * 4, 2, 0, 0, 0);
        wait_resp("lw_oor", 0, 1, LAT);
        op(1, DEP * 4, 2, 0, 32'hDEAD_BEEF, 0);
        wait_resp("sw_oor", 0, 1, 1);
        op(1, 32'h4, 3, 0, 32'h1234_5678, 0);
        wait_resp("sd_32", 0, 1, 1);
        op(0, 32'h0, 2, 0, 0, 0);
        wait_resp("lw_after_err", 32'h0000_8001, 0, LAT);

        op(0, 32'h0, 2, 0, 0, 0);
        k = 0;
        while (!o_ready && k < 20) begin
            k++;
            @(posedge i_clk);
            #2;
        end
        chk("load_ready_low", k, LAT + 1);
        op(0, 32'h10, 2, 0, 0, 1);
        op(0, 32'h12, 0, 1, 0, 1);
        op(1, 32'h14, 2, 0, 32'h0BAD_F00D, 1);
        op(0, 32'h14, 1, 0, 0, 0);

        op(1, 32'h40, 2, 0, 32'hCAFE_F00D, 0);
        wait_resp("sw6", 0, 0, 1);
        op(0, 32'h40, 2, 0, 0, 0);
        wait_resp("lw6a", 32'hCAFE_F00D, 0, LAT);
        op(0, 32'h40, 0, 0, 0, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        q.delete();
        last_d = 0;
        last_e = 0;
        busy_until = -1;
        repeat (LAT + 1) begin
            @(posedge i_clk);
            #2;
            chk("midrst_valid", o_valid, 0);
            chk("midrst_data", o_Data, 0);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        op(0, 32'h40, 2, 0, 0, 0);
        wait_resp("lw6b", 32'hCAFE_F00D, 0, LAT);

        for (int i = 0; i < 32; i++) begin
            op(1, i * 4, 2, 0, $urandom, (i != 31));
        end
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = DEP * 4 + $urandom_range(0, 255);
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else a = $urandom_range(0, 127);
            gap  = $urandom_range(0, 2);
            keep = (gap == 0) && (i != 399);
            op(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, keep);
            if (gap > 0) repeat (gap) @(posedge i_clk);
        end

        repeat (LAT + 4) @(posedge i_clk);
        #2;
        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
